cm_mem_ctrl_param: RTL and testbench
====================================

Name: cm_mem_ctrl_param

Overview:
Parametrised successor of the codemaker memory controller. Decodes one CPU-side request per cycle into three regions: N local SRAM banks, an arbitrated main-memory port, and a peripheral register window. Adds an explicit read-data-valid pulse, a decode-error flag, and generic bank count and widths. Sits between the codemaker core and the SRAM macros, the main-memory arbiter and the peripheral block.

Parameters:
ADDR_W, 14, CPU word-address width
DATA_W, 32, data width of all ports
NUM_BANKS, 6, local SRAM bank count (1..8)
BANK_ADDR_W, 9, word-address width inside one bank
MAIN_ADDR_W, 8, main-memory word-address width; region size 2**MAIN_ADDR_W
MAIN_BASE, 14'h2000, main-memory region base (aligned to region size)
PERIPH_ADDR_W, 4, peripheral word-address width; region size 2**PERIPH_ADDR_W
PERIPH_BASE, 14'h2100, peripheral region base (aligned)
TIMEOUT_CYCLES, 255, grant-wait limit (used only with the optional feature)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
req  in  1  CPU request strobe, accepted only when ready=1
we  in  1  1 = write, 0 = read
addr  in  ADDR_W  word address
wdata  in  DATA_W  write data
ready  out  1  controller can accept a request this cycle
rdata  out  DATA_W  read data, meaningful only when rdata_vld=1
rdata_vld  out  1  one-cycle pulse marking read completion
err  out  1  one-cycle pulse: unmapped access or grant timeout
bank_csb  out  NUM_BANKS  active-low chip select, one bit per bank
bank_web  out  NUM_BANKS  active-low write enable, one bit per bank
bank_addr  out  BANK_ADDR_W  common bank address
bank_din  out  DATA_W  common bank write data
bank_dout  in  NUM_BANKS*DATA_W  bank read data; bank i is bits [i*DATA_W +: DATA_W]
main_mem_req  out  1  main-memory access request
main_mem_grant  in  1  arbiter grant
main_mem_we  out  1  main-memory write enable, valid in the grant cycle only
main_mem_addr  out  MAIN_ADDR_W  main-memory address
main_mem_in  out  DATA_W  main-memory write data
main_mem_out  in  DATA_W  main-memory read data, valid the cycle after the grant
periph_we  out  1  peripheral write enable
periph_addr  out  PERIPH_ADDR_W  peripheral address
periph_in  out  DATA_W  peripheral write data
periph_out  in  DATA_W  peripheral read data, valid the cycle after the access

Behaviour:
- Regions:
  - LOCAL: addr < NUM_BANKS<<BANK_ADDR_W; bank index = addr[BANK_ADDR_W +: clog2(NUM_BANKS)].
  - MAIN: addr in [MAIN_BASE, MAIN_BASE + 2**MAIN_ADDR_W).
  - PERIPH: addr in [PERIPH_BASE, PERIPH_BASE + 2**PERIPH_ADDR_W).
  - Anything else is UNMAPPED, including bank indices >= NUM_BANKS.
- FSM states: IDLE, MAIN_WAIT, MAIN_RESP. ready=1 only in IDLE. A req while ready=0 is ignored and produces no side effects.
- IDLE, accepted LOCAL access:
  - Drive the selected bank's csb=0 combinationally in the same cycle; web=0 if we=1; bank_addr and bank_din follow the request.
  - Read: register the bank select; next cycle rdata=selected bank_dout and rdata_vld=1.
  - Write: no rdata_vld.
- IDLE, accepted PERIPH access: same timing as LOCAL. Drive periph_addr, periph_we and periph_in combinationally; a read returns periph_out next cycle with rdata_vld=1.
- IDLE, accepted MAIN access: latch we, address offset and wdata; assert main_mem_req the same cycle; go to MAIN_WAIT.
- MAIN_WAIT:
  - Hold main_mem_req=1.
  - On main_mem_grant, drive main_mem_addr, main_mem_we and main_mem_in from the latched values for that cycle only.
  - After the grant, a write returns to IDLE and a read goes to MAIN_RESP.
- MAIN_RESP: rdata=main_mem_out, rdata_vld=1, main_mem_req=0; go to IDLE.
- UNMAPPED access: no side effects. Next cycle err=1 and rdata=0; rdata_vld=1 for reads only.
- Back-to-back LOCAL/PERIPH reads: one per cycle, with rdata_vld high on consecutive cycles.
- Idle outputs: all csb=1, all web=1, all enables 0, addresses/data 0.
- Reset (rst=0, asynchronous): state=IDLE, ready=1, rdata=0, rdata_vld=0, err=0, main_mem_req=0, all latches cleared.
  - Reset mid-MAIN_WAIT drops main_mem_req immediately; the outstanding access is abandoned.

Optional Feature:
CM_MEMCTRL_TIMEOUT_EN
- Defined: a counter runs in MAIN_WAIT. If no grant arrives within TIMEOUT_CYCLES cycles, drop main_mem_req, return to IDLE, and pulse err=1 the next cycle (plus rdata_vld=1, rdata=0 if the access was a read). The counter clears on entry to MAIN_WAIT.
- Undefined: no counter; MAIN_WAIT waits indefinitely.

Decomposition:
- Package cm_mem_pkg: state encoding (IDLE=0, MAIN_WAIT=1, MAIN_RESP=2), a region enum (LOCAL/MAIN/PERIPH/UNMAPPED), and default base addresses.
- One sub-module, cm_addr_decode: combinational region classification plus bank index and offset extraction, reusable by other bus masters.

Test Plan:
- Reset, then read addr 0x0205 with bank1 dout=0xDEADBEEF -> bank_csb=6'b111101 during the request; next cycle rdata=0xDEADBEEF, rdata_vld=1.
- Write addr 0x0A10 with wdata=0x12345678 -> bank_csb[5]=0, bank_web[5]=0, bank_addr=0x010, bank_din=0x12345678; no rdata_vld.
- Read 0x2042 with grant delayed 3 cycles -> ready=0 for 4 cycles; main_mem_addr=0x42 in the grant cycle; main_mem_out=0xCAFE0001 returned with rdata_vld one cycle after the grant.
- Read 0x1000 (unmapped) -> next cycle err=1, rdata_vld=1, rdata=0; no csb asserted; no main_mem_req.
- Consecutive reads 0x2101 then 0x0003 -> rdata_vld high two consecutive cycles with periph_out then bank0 dout.
- Assert rst mid-MAIN_WAIT -> main_mem_req=0 immediately, ready=1 after release. With CM_MEMCTRL_TIMEOUT_EN, no grant for 255 cycles -> err pulse and return to IDLE.

Source files
------------

// File: rtl/cm_mem_pkg.sv
// rtl/cm_mem_pkg.sv - shared types, default bases and helpers for the cm memory controller
package cm_mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_MAIN_WAIT = 2'd1,
      ST_MAIN_RESP = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      RGN_LOCAL    = 2'd0,
      RGN_MAIN     = 2'd1,
      RGN_PERIPH   = 2'd2,
      RGN_UNMAPPED = 2'd3
   } region_t;

   // Where rdata is taken from in the response cycle
   typedef enum logic [1:0] {
      SRC_NONE   = 2'd0,
      SRC_BANK   = 2'd1,
      SRC_PERIPH = 2'd2,
      SRC_MAIN   = 2'd3
   } rsrc_t;

   localparam logic [13:0] DEF_MAIN_BASE   = 14'h2000;
   localparam logic [13:0] DEF_PERIPH_BASE = 14'h2100;

   // Bank index width; a single bank still gets a one-bit index
   function automatic int bidx_w(input int num_banks);
      return (num_banks > 1) ? $clog2(num_banks) : 1;
   endfunction

endpackage

// File: rtl/cm_addr_decode.sv
// rtl/cm_addr_decode.sv - combinational region classification with bank index and offsets
module cm_addr_decode
   import cm_mem_pkg::*;
#(
   parameter int ADDR_W        = 14,
   parameter int NUM_BANKS     = 6,
   parameter int BANK_ADDR_W   = 9,
   parameter int MAIN_ADDR_W   = 8,
   parameter logic [ADDR_W-1:0] MAIN_BASE   = ADDR_W'(DEF_MAIN_BASE),
   parameter int PERIPH_ADDR_W = 4,
   parameter logic [ADDR_W-1:0] PERIPH_BASE = ADDR_W'(DEF_PERIPH_BASE)
) (
   input  logic [ADDR_W-1:0]                addr,
   output region_t                          region,
   output logic [bidx_w(NUM_BANKS)-1:0]     bank_idx,
   output logic [BANK_ADDR_W-1:0]           bank_off,
   output logic [MAIN_ADDR_W-1:0]           main_off,
   output logic [PERIPH_ADDR_W-1:0]         periph_off
);

   localparam int BIDX_W = bidx_w(NUM_BANKS);
   localparam int unsigned LOCAL_LIMIT = NUM_BANKS << BANK_ADDR_W;

   logic is_local;
   logic is_main;
   logic is_periph;

   // The limit compare also rejects bank indices >= NUM_BANKS; main/periph bases are aligned
   always_comb begin
      is_local  = (32'(addr) < 32'(LOCAL_LIMIT));
      is_main   = (addr[ADDR_W-1:MAIN_ADDR_W] == MAIN_BASE[ADDR_W-1:MAIN_ADDR_W]);
      is_periph = (addr[ADDR_W-1:PERIPH_ADDR_W] == PERIPH_BASE[ADDR_W-1:PERIPH_ADDR_W]);
      if (is_local)       region = RGN_LOCAL;
      else if (is_main)   region = RGN_MAIN;
      else if (is_periph) region = RGN_PERIPH;
      else                region = RGN_UNMAPPED;
      bank_idx   = addr[BANK_ADDR_W +: BIDX_W];
      bank_off   = addr[BANK_ADDR_W-1:0];
      main_off   = addr[MAIN_ADDR_W-1:0];
      periph_off = addr[PERIPH_ADDR_W-1:0];
   end

endmodule

// File: rtl/cm_mem_ctrl_param.sv
// rtl/cm_mem_ctrl_param.sv - CPU request decoder to SRAM banks, main memory and peripherals (option: CM_MEMCTRL_TIMEOUT_EN)
module cm_mem_ctrl_param
   import cm_mem_pkg::*;
#(
   parameter int ADDR_W         = 14,
   parameter int DATA_W         = 32,
   parameter int NUM_BANKS      = 6,
   parameter int BANK_ADDR_W    = 9,
   parameter int MAIN_ADDR_W    = 8,
   parameter logic [ADDR_W-1:0] MAIN_BASE   = ADDR_W'(DEF_MAIN_BASE),
   parameter int PERIPH_ADDR_W  = 4,
   parameter logic [ADDR_W-1:0] PERIPH_BASE = ADDR_W'(DEF_PERIPH_BASE),
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        req,
   input  logic                        we,
   input  logic [ADDR_W-1:0]           addr,
   input  logic [DATA_W-1:0]           wdata,
   output logic                        ready,
   output logic [DATA_W-1:0]           rdata,
   output logic                        rdata_vld,
   output logic                        err,
   output logic [NUM_BANKS-1:0]        bank_csb,
   output logic [NUM_BANKS-1:0]        bank_web,
   output logic [BANK_ADDR_W-1:0]      bank_addr,
   output logic [DATA_W-1:0]           bank_din,
   input  logic [NUM_BANKS*DATA_W-1:0] bank_dout,
   output logic                        main_mem_req,
   input  logic                        main_mem_grant,
   output logic                        main_mem_we,
   output logic [MAIN_ADDR_W-1:0]      main_mem_addr,
   output logic [DATA_W-1:0]           main_mem_in,
   input  logic [DATA_W-1:0]           main_mem_out,
   output logic                        periph_we,
   output logic [PERIPH_ADDR_W-1:0]    periph_addr,
   output logic [DATA_W-1:0]           periph_in,
   input  logic [DATA_W-1:0]           periph_out
);

   localparam int BIDX_W = bidx_w(NUM_BANKS);

   state_t                     state;
   rsrc_t                      src_q;
   logic [BIDX_W-1:0]          sel_q;
   logic                       vld_q;
   logic                       err_q;
   logic                       m_we_q;
   logic [MAIN_ADDR_W-1:0]     m_addr_q;
   logic [DATA_W-1:0]          m_wdata_q;
   region_t                    region;
   logic [BIDX_W-1:0]          bank_idx;
   logic [BANK_ADDR_W-1:0]     bank_off;
   logic [MAIN_ADDR_W-1:0]     main_off;
   logic [PERIPH_ADDR_W-1:0]   periph_off;
   logic                       accept;
   logic                       granted;

`ifdef CM_MEMCTRL_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0]           to_cnt;
`endif

   cm_addr_decode #(
      .ADDR_W        (ADDR_W),
      .NUM_BANKS     (NUM_BANKS),
      .BANK_ADDR_W   (BANK_ADDR_W),
      .MAIN_ADDR_W   (MAIN_ADDR_W),
      .MAIN_BASE     (MAIN_BASE),
      .PERIPH_ADDR_W (PERIPH_ADDR_W),
      .PERIPH_BASE   (PERIPH_BASE)
   ) u_decode (
      .addr       (addr),
      .region     (region),
      .bank_idx   (bank_idx),
      .bank_off   (bank_off),
      .main_off   (main_off),
      .periph_off (periph_off)
   );

   assign ready     = (state == ST_IDLE);
   assign accept    = req & ready;
   assign granted   = (state == ST_MAIN_WAIT) & main_mem_grant;
   assign rdata_vld = vld_q;
   assign err       = err_q;

   // Same-cycle strobes toward banks, peripherals and the main-memory arbiter
   always_comb begin
      bank_csb      = '1;
      bank_web      = '1;
      bank_addr     = '0;
      bank_din      = '0;
      periph_we     = 1'b0;
      periph_addr   = '0;
      periph_in     = '0;
      main_mem_req  = (state == ST_MAIN_WAIT) || (accept && region == RGN_MAIN);
      main_mem_we   = 1'b0;
      main_mem_addr = '0;
      main_mem_in   = '0;
      if (accept && region == RGN_LOCAL) begin
         bank_addr = bank_off;
         bank_din  = wdata;
         for (int i = 0; i < NUM_BANKS; i++) begin
            if (BIDX_W'(i) == bank_idx) begin
               bank_csb[i] = 1'b0;
               bank_web[i] = ~we;
            end
         end
      end
      if (accept && region == RGN_PERIPH) begin
         periph_we   = we;
         periph_addr = periph_off;
         periph_in   = wdata;
      end
      if (granted) begin
         main_mem_we   = m_we_q;
         main_mem_addr = m_addr_q;
         main_mem_in   = m_wdata_q;
      end
   end

   // Response data comes straight from the source that is valid this cycle
   always_comb begin
      rdata = '0;
      case (src_q)
         SRC_BANK: begin
            for (int i = 0; i < NUM_BANKS; i++) begin
               if (BIDX_W'(i) == sel_q) rdata = bank_dout[i*DATA_W +: DATA_W];
            end
         end
         SRC_PERIPH: rdata = periph_out;
         SRC_MAIN:   rdata = main_mem_out;
         default:    rdata = '0;
      endcase
   end

   // Request FSM with registered valid/error pulses and main-access latches
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         src_q     <= SRC_NONE;
         sel_q     <= '0;
         vld_q     <= 1'b0;
         err_q     <= 1'b0;
         m_we_q    <= 1'b0;
         m_addr_q  <= '0;
         m_wdata_q <= '0;
`ifdef CM_MEMCTRL_TIMEOUT_EN
         to_cnt    <= '0;
`endif
      end else begin
         vld_q <= 1'b0;
         err_q <= 1'b0;
         src_q <= SRC_NONE;
         case (state)
            ST_IDLE: begin
               if (req) begin
                  case (region)
                     RGN_LOCAL: begin
                        if (!we) begin
                           vld_q <= 1'b1;
                           src_q <= SRC_BANK;
                           sel_q <= bank_idx;
                        end
                     end
                     RGN_PERIPH: begin
                        if (!we) begin
                           vld_q <= 1'b1;
                           src_q <= SRC_PERIPH;
                        end
                     end
                     RGN_MAIN: begin
                        m_we_q    <= we;
                        m_addr_q  <= main_off;
                        m_wdata_q <= wdata;
                        state     <= ST_MAIN_WAIT;
`ifdef CM_MEMCTRL_TIMEOUT_EN
                        to_cnt    <= '0;
`endif
                     end
                     default: begin
                        err_q <= 1'b1;
                        vld_q <= ~we;
                     end
                  endcase
               end
            end
            ST_MAIN_WAIT: begin
               if (main_mem_grant) begin
                  if (m_we_q) begin
                     state <= ST_IDLE;
                  end else begin
                     state <= ST_MAIN_RESP;
                     vld_q <= 1'b1;
                     src_q <= SRC_MAIN;
                  end
`ifdef CM_MEMCTRL_TIMEOUT_EN
               end else if (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  state <= ST_IDLE;
                  err_q <= 1'b1;
                  vld_q <= ~m_we_q;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
`endif
               end
            end
            ST_MAIN_RESP: state <= ST_IDLE;
            default:      state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cm_mem_ctrl_param.sv
// tb/tb_cm_mem_ctrl_param.sv - directed self-checking bench for cm_mem_ctrl_param
module tb_cm_mem_ctrl_param;

   localparam int ADDR_W        = 14;
   localparam int DATA_W        = 32;
   localparam int NUM_BANKS     = 6;
   localparam int BANK_ADDR_W   = 9;
   localparam int MAIN_ADDR_W   = 8;
   localparam int PERIPH_ADDR_W = 4;

   logic                        clk = 1'b0;
   logic                        rst = 1'b0;
   logic                        req = 1'b0;
   logic                        we = 1'b0;
   logic [ADDR_W-1:0]           addr = '0;
   logic [DATA_W-1:0]           wdata = '0;
   logic                        ready;
   logic [DATA_W-1:0]           rdata;
   logic                        rdata_vld;
   logic                        err;
   logic [NUM_BANKS-1:0]        bank_csb;
   logic [NUM_BANKS-1:0]        bank_web;
   logic [BANK_ADDR_W-1:0]      bank_addr;
   logic [DATA_W-1:0]           bank_din;
   logic [NUM_BANKS*DATA_W-1:0] bank_dout;
   logic                        main_mem_req;
   logic                        main_mem_grant = 1'b0;
   logic                        main_mem_we;
   logic [MAIN_ADDR_W-1:0]      main_mem_addr;
   logic [DATA_W-1:0]           main_mem_in;
   logic [DATA_W-1:0]           main_mem_out = 32'hCAFE0001;
   logic                        periph_we;
   logic [PERIPH_ADDR_W-1:0]    periph_addr;
   logic [DATA_W-1:0]           periph_in;
   logic [DATA_W-1:0]           periph_out = 32'h5EED0001;

   int n_chk  = 0;
   int n_pass = 0;

   cm_mem_ctrl_param dut (
      .clk            (clk),
      .rst            (rst),
      .req            (req),
      .we             (we),
      .addr           (addr),
      .wdata          (wdata),
      .ready          (ready),
      .rdata          (rdata),
      .rdata_vld      (rdata_vld),
      .err            (err),
      .bank_csb       (bank_csb),
      .bank_web       (bank_web),
      .bank_addr      (bank_addr),
      .bank_din       (bank_din),
      .bank_dout      (bank_dout),
      .main_mem_req   (main_mem_req),
      .main_mem_grant (main_mem_grant),
      .main_mem_we    (main_mem_we),
      .main_mem_addr  (main_mem_addr),
      .main_mem_in    (main_mem_in),
      .main_mem_out   (main_mem_out),
      .periph_we      (periph_we),
      .periph_addr    (periph_addr),
      .periph_in      (periph_in),
      .periph_out     (periph_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      req   = r;
      we    = w;
      addr  = a;
      wdata = d;
   endtask

   initial begin
      int busy;
      int vld_c;
      bank_dout = {32'hB5000005, 32'hB4000004, 32'hB3000003,
                   32'hB2000002, 32'hDEADBEEF, 32'hB0000000};

      // reset state
      @(negedge clk);
      check("rst_ready", ready, 1);
      check("rst_vld", rdata_vld, 0);
      check("rst_err", err, 0);
      check("rst_rdata", rdata, 0);
      check("rst_mreq", main_mem_req, 0);
      check("rst_csb", bank_csb, 6'h3F);
      check("rst_web", bank_web, 6'h3F);
      cyc();
      rst = 1'b1;

      // local read bank1
      cyc(); drive(1, 0, 14'h0205, 0);
      @(negedge clk);
      check("lrd_csb", bank_csb, 6'b111101);
      check("lrd_web", bank_web, 6'h3F);
      check("lrd_baddr", bank_addr, 9'h005);
      cyc(); drive(0, 0, 0, 0);
      @(negedge clk);
      check("lrd_vld", rdata_vld, 1);
      check("lrd_data", rdata, 32'hDEADBEEF);
      check("lrd_csb_idle", bank_csb, 6'h3F);

      // local write bank5
      cyc(); drive(1, 1, 14'h0A10, 32'h12345678);
      @(negedge clk);
      check("lwr_csb", bank_csb, 6'b011111);
      check("lwr_web", bank_web, 6'b011111);
      check("lwr_baddr", bank_addr, 9'h010);
      check("lwr_din", bank_din, 32'h12345678);
      cyc(); drive(0, 0, 0, 0);
      @(negedge clk);
      check("lwr_novld", rdata_vld, 0);
      check("lwr_noerr", err, 0);

      // main read with grant three cycles after the request
      cyc(); drive(1, 0, 14'h2042, 0);
      @(negedge clk);
      check("mrd_req0", main_mem_req, 1);
      check("mrd_addr0", main_mem_addr, 0);
      busy  = 0;
      vld_c = 0;
      for (int c = 1; c <= 6; c++) begin
         cyc();
         drive(0, 0, 0, 0);
         main_mem_grant = (c == 3);
         @(negedge clk);
         if (!ready) busy++;
         if (c == 2) check("mrd_req_wait", main_mem_req, 1);
         if (c == 3) begin
            check("mrd_gaddr", main_mem_addr, 8'h42);
            check("mrd_gwe", main_mem_we, 0);
         end
         if (rdata_vld) begin
            vld_c = c;
            check("mrd_data", rdata, 32'hCAFE0001);
            check("mrd_req_resp", main_mem_req, 0);
         end
      end
      main_mem_grant = 1'b0;
      check("mrd_busy", busy, 4);
      check("mrd_vld_cyc", vld_c, 4);

      // main write at top of region, granted in first wait cycle
      cyc(); drive(1, 1, 14'h20FF, 32'h0000AA55);
      cyc(); drive(0, 0, 0, 0); main_mem_grant = 1'b1;
      @(negedge clk);
      check("mwr_we", main_mem_we, 1);
      check("mwr_addr", main_mem_addr, 8'hFF);
      check("mwr_in", main_mem_in, 32'h0000AA55);
      cyc(); main_mem_grant = 1'b0;
      @(negedge clk);
      check("mwr_ready", ready, 1);
      check("mwr_novld", rdata_vld, 0);
      check("mwr_mreq", main_mem_req, 0);

      // unmapped read
      cyc(); drive(1, 0, 14'h1000, 0);
      @(negedge clk);
      check("un_csb", bank_csb, 6'h3F);
      check("un_mreq", main_mem_req, 0);
      cyc(); drive(0, 0, 0, 0);
      @(negedge clk);
      check("un_err", err, 1);
      check("un_vld", rdata_vld, 1);
      check("un_rdata", rdata, 0);

      // bank index 6 write is unmapped: error without valid
      cyc(); drive(1, 1, 14'h0C00, 32'hFFFFFFFF);
      @(negedge clk);
      check("b6_csb", bank_csb, 6'h3F);
      check("b6_web", bank_web, 6'h3F);
      cyc(); drive(0, 0, 0, 0);
      @(negedge clk);
      check("b6_err", err, 1);
      check("b6_novld", rdata_vld, 0);

      // just past the peripheral window
      cyc(); drive(1, 0, 14'h2110, 0);
      @(negedge clk);
      check("p_end_paddr", periph_addr, 0);
      cyc(); drive(0, 0, 0, 0);
      @(negedge clk);
      check("p_end_err", err, 1);

      // back-to-back periph then bank0 reads
      cyc(); drive(1, 0, 14'h2101, 0);
      @(negedge clk);
      check("pp_paddr", periph_addr, 4'h1);
      check("pp_pwe", periph_we, 0);
      cyc(); drive(1, 0, 14'h0003, 0);
      @(negedge clk);
      check("pp_vld1", rdata_vld, 1);
      check("pp_data1", rdata, 32'h5EED0001);
      check("pp_csb0", bank_csb, 6'b111110);
      cyc(); drive(0, 0, 0, 0);
      @(negedge clk);
      check("pp_vld2", rdata_vld, 1);
      check("pp_data2", rdata, 32'hB0000000);

      // peripheral write at top of window
      cyc(); drive(1, 1, 14'h210F, 32'h0BADF00D);
      @(negedge clk);
      check("pw_we", periph_we, 1);
      check("pw_addr", periph_addr, 4'hF);
      check("pw_in", periph_in, 32'h0BADF00D);
      cyc(); drive(0, 0, 0, 0);
      @(negedge clk);
      check("pw_novld", rdata_vld, 0);

      // reset while waiting for grant; a request while busy is ignored
      cyc(); drive(1, 0, 14'h2000, 0);
      cyc(); drive(1, 1, 14'h0001, 32'h11111111);
      @(negedge clk);
      check("rw_mreq", main_mem_req, 1);
      check("rw_busy", ready, 0);
      check("rw_ign_csb", bank_csb, 6'h3F);
      check("rw_ign_web", bank_web, 6'h3F);
      drive(0, 0, 0, 0);
      #1 rst = 1'b0;
      #1;
      check("rw_mreq_drop", main_mem_req, 0);
      check("rw_ready_rst", ready, 1);
      cyc(); rst = 1'b1;
      cyc();
      @(negedge clk);
      check("rw_ready_after", ready, 1);
      check("rw_novld", rdata_vld, 0);
      check("rw_mreq_after", main_mem_req, 0);

`ifdef CM_MEMCTRL_TIMEOUT_EN
      // grant never arrives: error one cycle after the 255th wait cycle
      begin
         int got;
         logic got_vld;
         got = 0;
         got_vld = 1'b0;
         cyc(); drive(1, 0, 14'h2010, 0);
         for (int c = 1; c < 400; c++) begin
            cyc();
            drive(0, 0, 0, 0);
            @(negedge clk);
            if (err) begin
               got = c;
               got_vld = rdata_vld;
               break;
            end
         end
         check("to_cycle", got, 256);
         check("to_vld", got_vld, 1);
         check("to_ready", ready, 1);
         check("to_mreq", main_mem_req, 0);
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
